// File: rtl/ibex_wb_port_arbiter.sv
// ibex_wb_port_arbiter
//   Shares the single integer and single FP register-file write ports among
//   three producers: LSU load data (never stalled), single-cycle ID/EX results
//   (back-pressured through ex_ready_o) and multi-cycle FPU completions
//   (buffered in a small FIFO, head served with starvation-bounded priority).
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   lsu_*_i                 LSU write request (always granted)
//   ex_*_i, ex_ready_o      EX result and its acceptance
//   fpu_*_i, fpu_ready_o    FPU completion push into the FIFO
//   rf_*_int_o, rf_*_fp_o   integer / FP register-file write ports
//   fifo_count_o            number of buffered FPU results
module ibex_wb_port_arbiter #(
  parameter int unsigned FifoDepth   = 2,
  parameter int unsigned StarveLimit = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           lsu_we_i,
  input  logic                           lsu_to_fp_i,
  input  logic [4:0]                     lsu_waddr_i,
  input  logic [31:0]                    lsu_wdata_i,
  input  logic                           ex_valid_i,
  input  logic                           ex_to_fp_i,
  input  logic [4:0]                     ex_waddr_i,
  input  logic [31:0]                    ex_wdata_i,
  output logic                           ex_ready_o,
  input  logic                           fpu_valid_i,
  input  logic                           fpu_to_fp_i,
  input  logic [4:0]                     fpu_waddr_i,
  input  logic [31:0]                    fpu_wdata_i,
  output logic                           fpu_ready_o,
  output logic                           rf_we_int_o,
  output logic [4:0]                     rf_waddr_int_o,
  output logic [31:0]                    rf_wdata_int_o,
  output logic                           rf_we_fp_o,
  output logic [4:0]                     rf_waddr_fp_o,
  output logic [31:0]                    rf_wdata_fp_o,
  output logic [$clog2(FifoDepth+1)-1:0] fifo_count_o
);

  localparam int unsigned CntW    = $clog2(FifoDepth + 1);
  localparam int unsigned PtrW    = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned StarveW = $clog2(StarveLimit + 1);

  typedef struct packed {
    logic        to_fp;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_entry_t;

  wb_entry_t           mem_reg [FifoDepth];
  logic [PtrW-1:0]     rd_ptr_reg, wr_ptr_reg;
  logic [CntW-1:0]     count_reg;
  logic [StarveW-1:0]  starve_reg;

  wb_entry_t head;
  logic      head_valid, force_head, push, pop;

  // Index 0 = integer RF, index 1 = FP RF.
  logic [1:0]  lsu_gnt, head_gnt, ex_gnt, ex_can;
  logic [1:0]  rf_we;
  logic [4:0]  rf_waddr [2];
  logic [31:0] rf_wdata [2];

  assign head       = mem_reg[rd_ptr_reg];
  assign head_valid = (count_reg != '0);
  assign force_head = (starve_reg >= StarveW'(StarveLimit));

  // No pop credit: a full FIFO refuses even when its head drains this cycle.
  assign fpu_ready_o  = rst_i | (count_reg < CntW'(FifoDepth));
  assign push         = fpu_valid_i & fpu_ready_o & ~rst_i;
  assign pop          = |head_gnt;
  assign fifo_count_o = rst_i ? '0 : count_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rf
      logic        lsu_hit, head_hit, ex_tgt;
      logic        sel_we;
      logic [4:0]  sel_addr;
      logic [31:0] sel_data;

      assign lsu_hit  = lsu_we_i & (lsu_to_fp_i == 1'(gi));
      assign head_hit = head_valid & (head.to_fp == 1'(gi));
      assign ex_tgt   = (ex_to_fp_i == 1'(gi));

      // EX would win this RF: independent of ex_valid_i so ready is stable.
      assign ex_can[gi]   = ~lsu_hit & ~(force_head & head_hit);
      assign lsu_gnt[gi]  = ~rst_i & lsu_hit;
      assign head_gnt[gi] = ~rst_i & head_hit & ~lsu_hit &
                            (force_head | ~(ex_valid_i & ex_tgt));
      assign ex_gnt[gi]   = ~rst_i & ex_valid_i & ex_tgt & ex_can[gi];

      always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        if (lsu_gnt[gi]) begin
          sel_we   = 1'b1;
          sel_addr = lsu_waddr_i;
          sel_data = lsu_wdata_i;
        end else if (head_gnt[gi]) begin
          sel_we   = 1'b1;
          sel_addr = head.waddr;
          sel_data = head.wdata;
        end else if (ex_gnt[gi]) begin
          sel_we   = 1'b1;
          sel_addr = ex_waddr_i;
          sel_data = ex_wdata_i;
        end
        // x0 writes are consumed but never reach the integer RF; f0 is real.
        if (gi == 0 && sel_addr == 5'd0) begin
          sel_we = 1'b0;
        end
        if (!sel_we) begin
          sel_addr = '0;
          sel_data = '0;
        end
      end

      assign rf_we[gi]    = sel_we;
      assign rf_waddr[gi] = sel_addr;
      assign rf_wdata[gi] = sel_data;
    end
  endgenerate

  assign ex_ready_o     = ~rst_i & (ex_to_fp_i ? ex_can[1] : ex_can[0]);
  assign rf_we_int_o    = rf_we[0];
  assign rf_waddr_int_o = rf_waddr[0];
  assign rf_wdata_int_o = rf_wdata[0];
  assign rf_we_fp_o     = rf_we[1];
  assign rf_waddr_fp_o  = rf_waddr[1];
  assign rf_wdata_fp_o  = rf_wdata[1];

  // Payload storage carries no reset; validity lives in the pointers/count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= '{to_fp: fpu_to_fp_i, waddr: fpu_waddr_i,
                               wdata: fpu_wdata_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      starve_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= (wr_ptr_reg == PtrW'(FifoDepth - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PtrW'(FifoDepth - 1)) ? '0 : rd_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 1'b1;
      end
      // Any denial of a valid head counts, including LSU-caused ones.
      if (!head_valid || pop) begin
        starve_reg <= '0;
      end else if (!force_head) begin
        starve_reg <= starve_reg + 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push && count_reg == CntW'(FifoDepth)))
        else $error("push into full FPU FIFO");
      assert ($onehot0({lsu_gnt[0], head_gnt[0], ex_gnt[0]}))
        else $error("multiple grants on integer RF");
      assert ($onehot0({lsu_gnt[1], head_gnt[1], ex_gnt[1]}))
        else $error("multiple grants on FP RF");
      assert (!lsu_we_i || (lsu_to_fp_i ? lsu_gnt[1] : lsu_gnt[0]))
        else $error("LSU write not granted");
    end
  end
`endif

endmodule
